// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: D-stage operand/destination info in,
// forwarding selects and stall controls out.
interface hazard_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] wa_D;
    logic [1:0] src_D;
    logic [3:0] MFRD1D;
    logic [3:0] MFRD2D;
    logic [3:0] MFALUAE;
    logic [3:0] MFALUBE;
    logic [3:0] MFWDM;
    logic       stall;
    logic       flush_E;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, wa_D, src_D,
        input  MFRD1D, MFRD2D, MFALUAE, MFALUBE, MFWDM,
        input  stall, flush_E
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, wa_D, src_D,
        output MFRD1D, MFRD2D, MFALUAE, MFALUBE, MFWDM,
        output stall, flush_E
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard/forwarding controller: E/M/W destination tag
// pipeline, Tuse/Tnew stall rule and nearest-stage forwarding selects.
module hazard_ctrl #(
    parameter logic [1:0] NONE_T = 2'd3
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_DM  = 2'd1,
        SRC_PC8 = 2'd2
    } src_t;

    logic [4:0] rs_E, rt_E, wa_E;
    logic [4:0] rt_M, wa_M;
    logic [4:0] wa_W;
    src_t       src_E, src_M, src_W;
    src_t       src_Dn;
    logic [1:0] tnew_E, tnew_M;
    logic       stall_rs, stall_rt, stall;

    function automatic logic hit(input logic [4:0] ra,
                                 input logic [4:0] wa);
        return (ra != 5'd0) && (ra == wa);
    endfunction

    function automatic logic rd_stall(input logic [4:0] ra,
                                      input logic [1:0] tuse,
                                      input logic [4:0] we,
                                      input logic [1:0] tne,
                                      input logic [4:0] wm,
                                      input logic [1:0] tnm);
        logic s;
        s = (hit(ra, we) && (tne > tuse)) ||
            (hit(ra, wm) && (tnm > tuse));
        return (tuse != NONE_T) && s;
    endfunction

    function automatic logic [3:0] fwd_d(input logic [4:0] ra,
                                         input logic [4:0] we,
                                         input src_t se,
                                         input logic [4:0] wm,
                                         input src_t sm,
                                         input logic [4:0] ww,
                                         input src_t sw);
        logic [3:0] sel;
        sel = 4'd0;
        if (hit(ra, we)) begin
            sel = (se == SRC_PC8) ? 4'd1 : 4'd0;
        end else if (hit(ra, wm)) begin
            case (sm)
                SRC_PC8: sel = 4'd2;
                SRC_ALU: sel = 4'd3;
                default: sel = 4'd0;
            endcase
        end else if (hit(ra, ww)) begin
            case (sw)
                SRC_PC8: sel = 4'd4;
                SRC_ALU: sel = 4'd5;
                SRC_DM:  sel = 4'd6;
                default: sel = 4'd0;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [3:0] fwd_e(input logic [4:0] ra,
                                         input logic [4:0] wm,
                                         input src_t sm,
                                         input logic [4:0] ww,
                                         input src_t sw);
        logic [3:0] sel;
        sel = 4'd0;
        if (hit(ra, wm)) begin
            case (sm)
                SRC_PC8: sel = 4'd1;
                SRC_ALU: sel = 4'd2;
                default: sel = 4'd0;
            endcase
        end else if (hit(ra, ww)) begin
            case (sw)
                SRC_PC8: sel = 4'd3;
                SRC_ALU: sel = 4'd4;
                SRC_DM:  sel = 4'd5;
                default: sel = 4'd0;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [3:0] fwd_m(input logic [4:0] ra,
                                         input logic [4:0] ww,
                                         input src_t sw);
        logic [3:0] sel;
        sel = 4'd0;
        if (hit(ra, ww)) begin
            case (sw)
                SRC_PC8: sel = 4'd1;
                SRC_ALU: sel = 4'd2;
                SRC_DM:  sel = 4'd3;
                default: sel = 4'd0;
            endcase
        end
        return sel;
    endfunction

    // Reserved source code 3 behaves as an ALU result.
    always_comb begin
        src_Dn = (hz.src_D == 2'd3) ? SRC_ALU : src_t'(hz.src_D);
    end

    // Cycles until each in-flight result exists.
    always_comb begin
        tnew_E = 2'd0;
        tnew_M = 2'd0;
        case (src_E)
            SRC_ALU: tnew_E = 2'd1;
            SRC_DM:  tnew_E = 2'd2;
            default: tnew_E = 2'd0;
        endcase
        if (src_M == SRC_DM) tnew_M = 2'd1;
    end

    // Stall when a producer cannot deliver before the reader needs it.
    always_comb begin
        stall_rs = rd_stall(hz.rs_D, hz.tuse_rs_D,
                            wa_E, tnew_E, wa_M, tnew_M);
        stall_rt = rd_stall(hz.rt_D, hz.tuse_rt_D,
                            wa_E, tnew_E, wa_M, tnew_M);
        stall    = stall_rs | stall_rt;
    end

    assign hz.stall   = stall;
    assign hz.flush_E = stall;

    // Forwarding selects, nearest producing stage first.
    always_comb begin
        hz.MFRD1D  = fwd_d(hz.rs_D, wa_E, src_E, wa_M, src_M, wa_W, src_W);
        hz.MFRD2D  = fwd_d(hz.rt_D, wa_E, src_E, wa_M, src_M, wa_W, src_W);
        hz.MFALUAE = fwd_e(rs_E, wa_M, src_M, wa_W, src_W);
        hz.MFALUBE = fwd_e(rt_E, wa_M, src_M, wa_W, src_W);
        hz.MFWDM   = fwd_m(rt_M, wa_W, src_W);
    end

    // Tag pipeline; a stall injects an all-zero bubble into E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_E  <= 5'd0;
            rt_E  <= 5'd0;
            wa_E  <= 5'd0;
            src_E <= SRC_ALU;
            rt_M  <= 5'd0;
            wa_M  <= 5'd0;
            src_M <= SRC_ALU;
            wa_W  <= 5'd0;
            src_W <= SRC_ALU;
        end else begin
            if (stall) begin
                rs_E  <= 5'd0;
                rt_E  <= 5'd0;
                wa_E  <= 5'd0;
                src_E <= SRC_ALU;
            end else begin
                rs_E  <= hz.rs_D;
                rt_E  <= hz.rt_D;
                wa_E  <= hz.wa_D;
                src_E <= src_Dn;
            end
            rt_M  <= rt_E;
            wa_M  <= wa_E;
            src_M <= src_E;
            wa_W  <= wa_M;
            src_W <= src_M;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle vector table plus stall
// duration sequences for producer/consumer pairs.
module tb_hazard_ctrl;

    logic clk;
    logic reset;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] trs;
        logic [1:0] trt;
        logic [4:0] wa;
        logic [1:0] src;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] m;
        logic       st;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    task automatic v(input int rst, input int rs, input int rt,
                     input int trs, input int trt, input int wa,
                     input int src, input int d1, input int d2,
                     input int ea, input int eb, input int m,
                     input int st);
        vec_t r;
        r.rst = 1'(rst);
        r.rs  = 5'(rs);
        r.rt  = 5'(rt);
        r.trs = 2'(trs);
        r.trt = 2'(trt);
        r.wa  = 5'(wa);
        r.src = 2'(src);
        r.d1  = 4'(d1);
        r.d2  = 4'(d2);
        r.ea  = 4'(ea);
        r.eb  = 4'(eb);
        r.m   = 4'(m);
        r.st  = 1'(st);
        vecs.push_back(r);
    endtask

    task automatic drive(input int rs, input int rt, input int trs,
                         input int trt, input int wa, input int src);
        hz.rs_D      = 5'(rs);
        hz.rt_D      = 5'(rt);
        hz.tuse_rs_D = 2'(trs);
        hz.tuse_rt_D = 2'(trt);
        hz.wa_D      = 5'(wa);
        hz.src_D     = 2'(src);
    endtask

    task automatic chk(input string name, input int idx,
                       input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d, expected %0d",
                     name, idx, got, exp);
        end
    endtask

    // Producer in D for one cycle, then consumer held in D until the
    // stall drops; checks stall length and the final D-stage select.
    task automatic stall_seq(input int id, input int wa, input int src,
                             input int tuse, input int exp_cyc,
                             input int exp_sel);
        int  cnt;
        bit  done;
        int  sel;
        cnt  = 0;
        done = 1'b0;
        sel  = 0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 3, 3, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 3, 3, wa, src);
        @(posedge clk);
        #1;
        drive(wa, 0, tuse, 3, 0, 0);
        for (int k = 0; k < 6 && !done; k++) begin
            @(negedge clk);
            if (hz.stall) begin
                cnt++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
                sel  = int'(hz.MFRD1D);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL seq_timeout [%0d]: stall still high", id);
        end
        chk("seq_stall_cycles", id, cnt, exp_cyc);
        chk("seq_MFRD1D", id, sel, exp_sel);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //  rst rs rt trs trt wa src | d1 d2 ea eb m st
        v(0,  5,  5, 1, 1,  5, 0,  0, 0, 0, 0, 0, 0);
        v(0,  5,  5, 0, 0,  5, 1,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  8, 0,  0, 0, 0, 0, 0, 0);
        v(1,  8,  0, 1, 3, 10, 0,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 2, 0, 0, 0);
        v(1,  0,  0, 1, 3,  9, 1,  0, 0, 0, 0, 0, 0);
        v(1,  9, 10, 1, 1, 11, 0,  0, 5, 0, 0, 0, 1);
        v(1,  9, 10, 1, 1, 11, 0,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 5, 0, 0, 0);
        v(1,  0,  0, 1, 3,  9, 1,  0, 0, 0, 0, 0, 0);
        v(1,  9,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1);
        v(1,  9,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1);
        v(1,  9,  0, 0, 0,  0, 0,  6, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3, 31, 2,  0, 0, 0, 0, 0, 0);
        v(1, 31,  0, 0, 3,  0, 0,  1, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3, 31, 2,  0, 0, 1, 0, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0);
        v(1, 31,  0, 0, 3,  0, 0,  2, 0, 0, 0, 0, 0);
        v(1, 31,  0, 0, 3,  0, 0,  4, 0, 3, 0, 0, 0);
        v(1,  0,  0, 3, 3,  4, 1,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  4, 0,  0, 0, 0, 0, 0, 0);
        v(1,  0,  4, 3, 1, 12, 0,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 0, 2, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 2, 0);
        v(1,  0,  0, 3, 3,  0, 1,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 1, 3,  3, 1,  0, 0, 0, 0, 0, 0);
        v(1,  0,  3, 1, 2,  0, 0,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 3, 0);
        v(1,  0,  0, 3, 3, 13, 3,  0, 0, 0, 0, 0, 0);
        v(1, 13,  0, 0, 3,  0, 0,  0, 0, 0, 0, 0, 1);
        v(1, 13,  0, 0, 3,  0, 0,  3, 0, 0, 0, 0, 0);
        v(1,  0,  0, 3, 3,  0, 0,  0, 0, 4, 0, 0, 0);
        v(1,  0,  0, 3, 3, 20, 1,  0, 0, 0, 0, 0, 0);
        v(0, 20,  0, 0, 3, 20, 1,  0, 0, 0, 0, 0, 0);
        v(1, 20,  0, 0, 3,  0, 0,  0, 0, 0, 0, 0, 0);

        reset = 1'b1;
        drive(0, 0, 3, 3, 0, 0);
        #2;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            drive(int'(vecs[i].rs), int'(vecs[i].rt),
                  int'(vecs[i].trs), int'(vecs[i].trt),
                  int'(vecs[i].wa), int'(vecs[i].src));
            @(negedge clk);
            chk("MFRD1D", i, int'(hz.MFRD1D), int'(vecs[i].d1));
            chk("MFRD2D", i, int'(hz.MFRD2D), int'(vecs[i].d2));
            chk("MFALUAE", i, int'(hz.MFALUAE), int'(vecs[i].ea));
            chk("MFALUBE", i, int'(hz.MFALUBE), int'(vecs[i].eb));
            chk("MFWDM", i, int'(hz.MFWDM), int'(vecs[i].m));
            chk("stall", i, int'(hz.stall), int'(vecs[i].st));
            chk("flush_E", i, int'(hz.flush_E), int'(vecs[i].st));
            @(posedge clk);
            #1;
        end

        reset = 1'b1;
        stall_seq(0, 7, 1, 0, 2, 6);
        stall_seq(1, 6, 0, 0, 1, 3);
        stall_seq(2, 31, 2, 0, 0, 1);
        stall_seq(3, 5, 1, 1, 1, 0);
        stall_seq(4, 14, 1, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage MIPS pipeline. It tracks, per stage, which register each in-flight instruction writes and where the result comes from. From that it produces the select codes consumed by the forwarding multiplexers (RF read ports in D, ALU operands in E, store data in M) and the stall/bubble controls for the front end. Tag tracking is sequential: a D→E→M→W tag pipeline that advances in lockstep with the datapath pipeline registers.

## Interface
Parameters:
- NONE_T, 2'd3, Tuse value meaning "operand not read".

Ports:
- clk  in  1  pipeline clock; all tag registers update on rising edge.
- reset  in  1  asynchronous, active-low; clears every tag register.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- tuse_rs_D  in  2  stage offset at which rs is first needed: 0 = D (branch/jr), 1 = E, 2 = M, 3 = unused.
- tuse_rt_D  in  2  same, for rt.
- wa_D  in  5  destination register of the instruction in D; 0 = no write.
- src_D  in  2  result source: 0 = ALU, 1 = DM, 2 = PC+8; 3 is reserved and treated as 0.
- MFRD1D, MFRD2D  out  4  D-stage select: 0 RF, 1 EtoD_PC8, 2 MtoD_PC8, 3 MtoD_ALU, 4 WtoD_PC8, 5 WtoD_ALU, 6 WtoD_DM.
- MFALUAE, MFALUBE  out  4  E-stage select: 0 RF, 1 MtoE_PC8, 2 MtoE_ALU, 3 WtoE_PC8, 4 WtoE_ALU, 5 WtoE_DM.
- MFWDM  out  4  M-stage select: 0 RF, 1 WtoM_PC8, 2 WtoM_ALU, 3 WtoM_DM.
- stall  out  1  freeze PC and the F/D register.
- flush_E  out  1  load a bubble into the D/E register; always equal to stall.

## Operation
- Tag registers:
  - E stage: rs_E, rt_E, wa_E, src_E.
  - M stage: rt_M, wa_M, src_M.
  - W stage: wa_W, src_W.
- On each clock:
  - E tags load from the D inputs, or load all zeros when stall=1.
  - M tags load from E; W tags load from M.
- Tnew (cycles until the result exists) is derived from src and stage:
  - ALU: E=1, M=0, W=0.
  - DM: E=2, M=1, W=0.
  - PC+8: 0 in every stage.
- A register read matches a stage when its source register equals that stage's wa and is nonzero. $0 never matches and never stalls.
- Stall rule, evaluated for rs and for rt, skipping any read with tuse=3:
  - stall if it matches E and Tnew_E > tuse, or
  - stall if it matches M and Tnew_M > tuse.
  - stall is the OR of both reads.
- D forwarding for rs (rt identical), first hit in priority order:
  - E with src=PC8 → 1.
  - M with src=PC8 → 2; M with src=ALU → 3.
  - W with PC8 / ALU / DM → 4 / 5 / 6.
  - otherwise 0.
  - An M match with src=DM yields 0; the stall rule guarantees this never reaches a consumer.
- E forwarding for rs_E/rt_E: M hit → 1 (PC8) or 2 (ALU); otherwise W hit → 3 / 4 / 5; otherwise 0.
- M forwarding for rt_M: W hit → 1 / 2 / 3; otherwise 0.
- The nearest stage always wins when several stages hold the same wa.

## Timing
- All outputs are combinational from the D inputs and the registered tags, with no internal delay. They are valid in the same cycle the D inputs are valid.
- Reset asserted (reset=0) forces all tags to 0 immediately. Resulting outputs: all selects 0, stall=0, flush_E=0.
- Reset released mid-program: the tags are empty, so no forwarding occurs until new instructions enter.
- Stall duration:
  - load→ALU-use (tuse 1): 1 cycle.
  - load→branch (tuse 0): 2 cycles.
  - ALU→branch: 1 cycle.
  - store data (tuse 2): never stalls.
- During a stall the M and W tags keep advancing. Once the producer reaches a stage where Tnew ≤ tuse, stall deasserts and the D-stage forward select becomes valid in that same cycle.
- A bubble carries wa=0 and therefore never matches.

## Test plan
- Reset: hold reset=0 with arbitrary D inputs (rs_D=5, wa_D=5) → all selects 0, stall=0. Release reset, then clock once with wa_D=8, src_D=0 → next cycle rs_D=8, tuse=1 gives stall=0, MFRD1D=0. The E stage then shows MFALUAE=0, and the following cycle shows MFALUAE=2 once the producer is in M.
- Load-use: lw $9 (wa=9, src=1), then add using rs=9, tuse=1 → stall=1 and flush_E=1 for exactly 1 cycle. Next cycle: stall=0, MFRD1D=0, and with the consumer in E, MFALUAE=5 (WtoE_DM).
- Load→beq (rs=9, tuse=0) → stall for 2 cycles, then MFRD1D=6.
- jal (wa=31, src=2) followed by jr $31 (tuse=0) → no stall, MFRD1D=1. The same pair with one nop between → MFRD1D=2.
- Priority: writes to $4 present in both M (ALU) and W (DM), consumer reads rt=4 in E → MFALUBE=2.
- $0 and store data:
  - writer with wa=0, then reader with rs=0 → no stall, selects 0.
  - lw $3, then sw with rt=3, tuse=2 → no stall; MFWDM=3 when the sw reaches M.
